// File: rtl/dino_pkg.sv
// Shared types and constants for the obstacle collision block.
package dino_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    CHK1 = 3'd2,
    CHK2 = 3'd3,
    HIT  = 3'd4
  } state_t;

  localparam logic [5:0] DINO_H_STAND = 6'd24;
  localparam logic [5:0] DINO_H_DUCK  = 6'd12;

  // Obstacle hitbox: width in position units and vertical span [y_lo, y_hi).
  typedef struct packed {
    logic [4:0] w;
    logic [5:0] y_lo;
    logic [5:0] y_hi;
  } hitbox_t;

  localparam hitbox_t HB_SMALL_CACTUS = '{w: 5'd8,  y_lo: 6'd0,  y_hi: 6'd16};
  localparam hitbox_t HB_LARGE_CACTUS = '{w: 5'd12, y_lo: 6'd0,  y_hi: 6'd24};
  localparam hitbox_t HB_LOW_BIRD     = '{w: 5'd16, y_lo: 6'd14, y_hi: 6'd26};
  localparam hitbox_t HB_HIGH_BIRD    = '{w: 5'd16, y_lo: 6'd28, y_hi: 6'd40};

  // Map a 3-bit obstacle type onto its hitbox.
  function automatic hitbox_t type_hitbox(input logic [2:0] t);
    hitbox_t hb;
    case (t)
      3'd4, 3'd5: hb = HB_LARGE_CACTUS;
      3'd6:       hb = HB_LOW_BIRD;
      3'd7:       hb = HB_HIGH_BIRD;
      default:    hb = HB_SMALL_CACTUS;
    endcase
    return hb;
  endfunction

endpackage

// File: rtl/obstacle_hitbox.sv
// Combinational axis-aligned overlap test between one obstacle and the dino.
module obstacle_hitbox
  import dino_pkg::*;
#(
  parameter int POS_W  = 10,
  parameter int DINO_X = 40,
  parameter int DINO_W = 12
) (
  input  logic [POS_W-1:0] pos,
  input  logic [2:0]       obs_type,
  input  logic [5:0]       dino_y,
  input  logic [5:0]       dino_h,
  output logic             hit
);

  localparam logic [10:0] DX_LO = 11'(DINO_X);
  localparam logic [10:0] DX_HI = 11'(DINO_X + DINO_W);

  hitbox_t     hb;
  logic [10:0] ox_lo;
  logic [10:0] ox_hi;
  logic [10:0] oy_lo;
  logic [10:0] oy_hi;
  logic [10:0] dy_lo;
  logic [10:0] dy_hi;

  // Strict-inequality overlap on both axes; 11-bit sums so edges never wrap.
  always_comb begin
    hb    = type_hitbox(obs_type);
    ox_lo = 11'(pos);
    ox_hi = 11'(pos) + 11'(hb.w);
    oy_lo = 11'(hb.y_lo);
    oy_hi = 11'(hb.y_hi);
    dy_lo = 11'(dino_y);
    dy_hi = 11'(dino_y) + 11'(dino_h);
    hit   = (pos != '0) &&
            (ox_lo < DX_HI) && (DX_LO < ox_hi) &&
            (oy_lo < dy_hi) && (dy_lo < oy_hi);
  end

endmodule

// File: rtl/obstacle_collision.sv
// Frame-by-frame collision checker with run/freeze FSM and survived-frame score.
module obstacle_collision
  import dino_pkg::*;
#(
  parameter int CONV   = 0,
  parameter int DINO_X = 40,
  parameter int DINO_W = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            game_start,
  input  logic            frame_tick,
  input  logic [9-CONV:0] obstacle1_pos,
  input  logic [9-CONV:0] obstacle2_pos,
  input  logic [2:0]      obstacle1_type,
  input  logic [2:0]      obstacle2_type,
  input  logic [5:0]      dino_y,
  input  logic            dino_duck,
  output logic            game_frozen,
  output logic            collision,
  output logic            hit_obstacle,
  output logic [15:0]     score
);

  localparam int POS_W = 10 - CONV;

  state_t state_q;
  state_t state_d;

  // Frame snapshot taken on the accepted tick.
  logic [POS_W-1:0] snap1_pos_q;
  logic [POS_W-1:0] snap2_pos_q;
  logic [2:0]       snap1_type_q;
  logic [2:0]       snap2_type_q;
  logic [5:0]       snap_y_q;
  logic             snap_duck_q;
  logic             snap_en;

  // Check results: slot-1 result and the one-cycle pending frame verdict.
  logic hit1_q,       hit1_d;
  logic pend_hit_q,   pend_hit_d;
  logic pend_clean_q, pend_clean_d;
  logic pend_idx_q,   pend_idx_d;

  logic        frozen_d;
  logic        collision_d;
  logic        hit_obs_d;
  logic [15:0] score_d;

  // Shared comparator inputs.
  logic [POS_W-1:0] cmp_pos;
  logic [2:0]       cmp_type;
  logic [5:0]       cmp_h;
  logic             cmp_hit;

  // Route slot 2 into the comparator during CHK2, slot 1 otherwise.
  always_comb begin
    cmp_pos  = (state_q == CHK2) ? snap2_pos_q  : snap1_pos_q;
    cmp_type = (state_q == CHK2) ? snap2_type_q : snap1_type_q;
    cmp_h    = snap_duck_q ? DINO_H_DUCK : DINO_H_STAND;
  end

  obstacle_hitbox #(
    .POS_W  (POS_W),
    .DINO_X (DINO_X),
    .DINO_W (DINO_W)
  ) u_hitbox (
    .pos      (cmp_pos),
    .obs_type (cmp_type),
    .dino_y   (snap_y_q),
    .dino_h   (cmp_h),
    .hit      (cmp_hit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus next values of the registered outputs and check results.
  always_comb begin
    state_d      = state_q;
    snap_en      = 1'b0;
    hit1_d       = hit1_q;
    pend_hit_d   = 1'b0;
    pend_clean_d = 1'b0;
    pend_idx_d   = 1'b0;
    frozen_d     = (state_q == IDLE) || (state_q == HIT);
    collision_d  = pend_hit_q;
    hit_obs_d    = pend_hit_q ? pend_idx_q : hit_obstacle;
    score_d      = (pend_clean_q && (score != 16'hFFFF)) ? score + 16'd1 : score;
    if (game_start) begin
      // Restart wins over everything, including a verdict still in flight.
      state_d     = RUN;
      hit1_d      = 1'b0;
      collision_d = 1'b0;
      hit_obs_d   = 1'b0;
      score_d     = 16'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (frame_tick) begin
            snap_en = 1'b1;
            state_d = CHK1;
          end
        end
        CHK1: begin
          hit1_d  = cmp_hit;
          state_d = CHK2;
        end
        CHK2: begin
          if (hit1_q || cmp_hit) begin
            state_d    = HIT;
            pend_hit_d = 1'b1;
            pend_idx_d = ~hit1_q;
          end else begin
            state_d      = RUN;
            pend_clean_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Snapshot, check-result and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap1_pos_q  <= '0;
      snap2_pos_q  <= '0;
      snap1_type_q <= '0;
      snap2_type_q <= '0;
      snap_y_q     <= '0;
      snap_duck_q  <= 1'b0;
      hit1_q       <= 1'b0;
      pend_hit_q   <= 1'b0;
      pend_clean_q <= 1'b0;
      pend_idx_q   <= 1'b0;
      game_frozen  <= 1'b1;
      collision    <= 1'b0;
      hit_obstacle <= 1'b0;
      score        <= 16'd0;
    end else begin
      if (snap_en) begin
        snap1_pos_q  <= obstacle1_pos;
        snap2_pos_q  <= obstacle2_pos;
        snap1_type_q <= obstacle1_type;
        snap2_type_q <= obstacle2_type;
        snap_y_q     <= dino_y;
        snap_duck_q  <= dino_duck;
      end
      hit1_q       <= hit1_d;
      pend_hit_q   <= pend_hit_d;
      pend_clean_q <= pend_clean_d;
      pend_idx_q   <= pend_idx_d;
      game_frozen  <= frozen_d;
      collision    <= collision_d;
      hit_obstacle <= hit_obs_d;
      score        <= score_d;
    end
  end

endmodule

// File: tb/tb_obstacle_collision.sv
// Directed bench for obstacle_collision with hand-computed expectations.
module tb_obstacle_collision;
  import dino_pkg::*;

  logic        clk;
  logic        rst;
  logic        game_start;
  logic        frame_tick;
  logic [9:0]  obstacle1_pos;
  logic [9:0]  obstacle2_pos;
  logic [2:0]  obstacle1_type;
  logic [2:0]  obstacle2_type;
  logic [5:0]  dino_y;
  logic        dino_duck;
  logic        game_frozen;
  logic        collision;
  logic        hit_obstacle;
  logic [15:0] score;

  int n_checks;
  int n_pass;

  obstacle_collision #(
    .CONV   (0),
    .DINO_X (40),
    .DINO_W (12)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .game_start     (game_start),
    .frame_tick     (frame_tick),
    .obstacle1_pos  (obstacle1_pos),
    .obstacle2_pos  (obstacle2_pos),
    .obstacle1_type (obstacle1_type),
    .obstacle2_type (obstacle2_type),
    .dino_y         (dino_y),
    .dino_duck      (dino_duck),
    .game_frozen    (game_frozen),
    .collision      (collision),
    .hit_obstacle   (hit_obstacle),
    .score          (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic set_inputs(input logic [9:0] p1, input logic [2:0] t1,
                            input logic [9:0] p2, input logic [2:0] t2,
                            input logic [5:0] y, input logic duck);
    obstacle1_pos  = p1;
    obstacle1_type = t1;
    obstacle2_pos  = p2;
    obstacle2_type = t2;
    dino_y         = y;
    dino_duck      = duck;
  endtask

  // One frame: tick sampled at edge T, verdict visible after edge T+3.
  task automatic run_frame(input string tag,
                           input logic [9:0] p1, input logic [2:0] t1,
                           input logic [9:0] p2, input logic [2:0] t2,
                           input logic [5:0] y, input logic duck,
                           input logic exp_hit, input logic exp_idx,
                           input logic [15:0] exp_score);
    @(negedge clk);
    set_inputs(p1, t1, p2, t2, y, duck);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    set_inputs(10'd0, 3'd0, 10'd0, 3'd0, 6'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_coll_early"}, 32'(collision), 32'd0);
    @(negedge clk);
    chk({tag, "_coll"},   32'(collision),   32'(exp_hit));
    chk({tag, "_frozen"}, 32'(game_frozen), 32'(exp_hit));
    chk({tag, "_score"},  32'(score),       32'(exp_score));
    if (exp_hit) chk({tag, "_idx"}, 32'(hit_obstacle), 32'(exp_idx));
    @(negedge clk);
    chk({tag, "_coll_drop"}, 32'(collision), 32'd0);
    if (exp_hit) chk({tag, "_idx_hold"}, 32'(hit_obstacle), 32'(exp_idx));
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    game_start = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
    chk({tag, "_score0"}, 32'(score), 32'd0);
    chk({tag, "_idx0"},   32'(hit_obstacle), 32'd0);
    chk({tag, "_state"},  32'(dut.state_q), 32'(RUN));
    @(negedge clk);
    chk({tag, "_unfrozen"}, 32'(game_frozen), 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    game_start = 1'b0;
    frame_tick = 1'b0;
    set_inputs(10'd0, 3'd0, 10'd0, 3'd0, 6'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_frozen", 32'(game_frozen),  32'd1);
    chk("rst_coll",   32'(collision),    32'd0);
    chk("rst_idx",    32'(hit_obstacle), 32'd0);
    chk("rst_score",  32'(score),        32'd0);
    chk("rst_state",  32'(dut.state_q),  32'(IDLE));
    rst = 1'b0;

    // Tick in IDLE is ignored even with a hitting obstacle.
    @(negedge clk);
    set_inputs(10'd45, 3'd0, 10'd0, 3'd0, 6'd0, 1'b0);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("idle_state", 32'(dut.state_q), 32'(IDLE));
    repeat (3) @(negedge clk);
    chk("idle_coll",   32'(collision),   32'd0);
    chk("idle_frozen", 32'(game_frozen), 32'd1);

    // Start from IDLE: freeze releases one edge after start is sampled.
    @(negedge clk);
    game_start = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
    chk("start_state",  32'(dut.state_q), 32'(RUN));
    chk("start_frozen", 32'(game_frozen), 32'd1);
    @(negedge clk);
    chk("start_unfrozen", 32'(game_frozen), 32'd0);

    // Clean frames.
    run_frame("jump",      10'd45, 3'd0, 10'd0,  3'd0, 6'd20, 1'b0, 1'b0, 1'b0, 16'd1);
    run_frame("touch52",   10'd52, 3'd0, 10'd0,  3'd0, 6'd0,  1'b0, 1'b0, 1'b0, 16'd2);
    run_frame("duck_bird", 10'd0,  3'd0, 10'd38, 3'd6, 6'd0,  1'b0 | 1'b1, 1'b0, 1'b0, 16'd3);
    run_frame("touch_lg",  10'd28, 3'd4, 10'd0,  3'd0, 6'd0,  1'b0, 1'b0, 1'b0, 16'd4);
    run_frame("hi_bird",   10'd40, 3'd7, 10'd0,  3'd0, 6'd0,  1'b0, 1'b0, 1'b0, 16'd5);

    // Hitting frames.
    run_frame("edge51",    10'd51, 3'd0, 10'd0,  3'd0, 6'd0,  1'b0, 1'b1, 1'b0, 16'd5);
    do_start("rs1");
    run_frame("cactus45",  10'd45, 3'd0, 10'd0,  3'd0, 6'd0,  1'b0, 1'b1, 1'b0, 16'd0);
    do_start("rs2");
    run_frame("stand_bird",10'd0,  3'd0, 10'd38, 3'd6, 6'd0,  1'b0, 1'b1, 1'b1, 16'd0);
    do_start("rs3");
    run_frame("large29",   10'd29, 3'd5, 10'd0,  3'd0, 6'd0,  1'b0, 1'b1, 1'b0, 16'd0);
    do_start("rs4");
    run_frame("both",      10'd40, 3'd7, 10'd38, 3'd6, 6'd20, 1'b0, 1'b1, 1'b0, 16'd0);
    do_start("rs5");

    // Tick and start together: restart wins, no check runs.
    @(negedge clk);
    set_inputs(10'd45, 3'd0, 10'd0, 3'd0, 6'd0, 1'b0);
    game_start = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
    frame_tick = 1'b0;
    chk("same_state", 32'(dut.state_q), 32'(RUN));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("same_coll%0d", i), 32'(collision), 32'd0);
    end
    chk("same_score",  32'(score),       32'd0);
    chk("same_frozen", 32'(game_frozen), 32'd0);

    // Reset in the middle of a check.
    run_frame("pre_rst1", 10'd0, 3'd0, 10'd0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0, 16'd1);
    run_frame("pre_rst2", 10'd0, 3'd0, 10'd0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0, 16'd2);
    @(negedge clk);
    set_inputs(10'd45, 3'd0, 10'd0, 3'd0, 6'd0, 1'b0);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("mid_state_chk1", 32'(dut.state_q), 32'(CHK1));
    rst = 1'b1;
    #1;
    chk("mid_rst_state",  32'(dut.state_q), 32'(IDLE));
    chk("mid_rst_frozen", 32'(game_frozen), 32'd1);
    chk("mid_rst_score",  32'(score),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_coll",  32'(collision),   32'd0);
    chk("post_rst_state", 32'(dut.state_q), 32'(IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/obstacle_collision.md
# obstacle_collision

Consumer side of the obstacle stream. On each frame tick it samples both obstacle slots (position plus type) with the dino's vertical state and tests axis-aligned hitbox overlap, evaluating one slot per cycle through a single shared comparator. It owns the run/freeze state machine, drives `game_frozen` back to the obstacle generator and the dino physics, and keeps the survived-frame score.

## Interface
- `CONV`, default 0: position LSB index; positions are `[9:CONV]`, the same as the obstacle generator.
- `DINO_X`, default 40: left edge of the dino, in position units.
- `DINO_W`, default 12: dino width, in position units.
- `clk`, in, 1: system clock. All state is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `game_start`, in, 1: synchronous restart pulse.
- `frame_tick`, in, 1: one-cycle pulse per frame (vblank).
- `obstacle1_pos`, `obstacle2_pos`, in, 10-CONV: x position. 0 means the slot is inactive.
- `obstacle1_type`, `obstacle2_type`, in, 3: obstacle type.
- `dino_y`, in, 6: dino bottom height above the ground.
- `dino_duck`, in, 1: dino is ducking.
- `game_frozen`, out, 1: freeze request to the obstacle generator and physics.
- `collision`, out, 1: one-cycle pulse when a hit is detected.
- `hit_obstacle`, out, 1: index of the slot that hit (0 = slot 1, 1 = slot 2). Held until restart.
- `score`, out, 16: count of frames survived, saturating.

## Operation
- FSM states: IDLE, RUN, CHK1, CHK2, HIT.
- Reset values: state IDLE, `game_frozen`=1, `collision`=0, `hit_obstacle`=0, `score`=0, snapshot registers 0.
- IDLE and HIT keep `game_frozen`=1 and ignore `frame_tick`.
- `game_start` in any state: next state RUN, `score`=0, `hit_obstacle`=0, pending result discarded. `game_start` has priority over `frame_tick` in the same cycle.
- RUN with `frame_tick`: snapshot all position, type, `dino_y` and `dino_duck` inputs, then go to CHK1.
- CHK1: test slot 1 and store the result in `hit1`. Go to CHK2.
- CHK2: test slot 2.
  - If either slot hit: go to HIT, set `game_frozen`=1, pulse `collision`. `hit_obstacle` is 0 if slot 1 hit (slot 1 wins ties), otherwise 1.
  - If neither hit: go to RUN and increment `score`. `score` saturates at 16'hFFFF.
- A `frame_tick` arriving during CHK1 or CHK2 is dropped.
- Hitbox test, with all sums computed at 11 bits so nothing wraps:
  - A slot with position 0 never hits.
  - Obstacle x span is [pos, pos+W). Dino x span is [DINO_X, DINO_X+DINO_W).
  - Dino y span is [dino_y, dino_y+DH), with DH=24 standing and DH=12 ducking.
  - A hit requires overlap on both axes, using strict inequalities: lo_a < hi_b and lo_b < hi_a. Boxes that only touch at an edge do not hit.
- Type table:
  - Types 0–3, small cactus: W=8, y span [0,16).
  - Types 4–5, large cactus: W=12, y span [0,24).
  - Type 6, low bird: W=16, y span [14,26).
  - Type 7, high bird: W=16, y span [28,40).

## Timing
- Let the tick be sampled at edge T. Then CHK1 is at T+1, CHK2 at T+2, and `collision` and `game_frozen` rise at T+3.
- `score` updates at T+3 on a clean frame.
- `game_frozen` falls on the edge after `game_start` is sampled.
- `collision` is high for exactly one cycle per hit.
- Asserting `rst` at any point, including mid-check, forces the reset values immediately.
- The outputs `game_frozen`, `collision`, `hit_obstacle` and `score` are all registered.

## Structure
- Package `dino_pkg` holds:
  - the FSM state enum;
  - constants `DINO_H_STAND`=24 and `DINO_H_DUCK`=12;
  - the per-type hitbox constants (W, y_lo, y_hi).
- Sub-module `obstacle_hitbox`: purely combinational. It takes pos, type, dino_y, DH, DINO_X and DINO_W and returns `hit`. The FSM instantiates it once and multiplexes the slot into it.

## Test plan
- Slot 1 at pos=45, type 0, `dino_y`=0, standing; slot 2 at 0. Tick → `collision` pulse at T+3, `hit_obstacle`=0, `game_frozen`=1, `score` unchanged.
- Same setup with `dino_y`=20 (jumping). Tick → no collision, `score` 0→1, `game_frozen` stays 0.
- Edge case: slot 1 type 0 at pos=52 → no hit, since spans [52,60) and [40,52) only touch. Repeat with pos=51 → hit.
- Slot 2 type 6 at pos=38, `dino_y`=0. Ducking → no hit and score increments. Standing → hit with `hit_obstacle`=1.
- Both slots overlapping on the same tick → `hit_obstacle`=0. Then `game_start` → `score`=0, `game_frozen`=0 one cycle later, state RUN.
- `frame_tick` and `game_start` in the same cycle → state RUN, no check performed. Asserting `rst` during CHK1 → IDLE, `game_frozen`=1, `score`=0.
